// File: rtl/minisys_mdu_pkg.sv
// Shared definitions for the Minisys-1A multiply/divide unit: op codes, FSM states
// and the divide-by-zero LO fill pattern.
package minisys_mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // Widest WIDTH the fill helper can produce.
    localparam int MDU_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic [MDU_MAX_WIDTH-1:0] dbz_lo_fill(input int width);
        logic [MDU_MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MDU_MAX_WIDTH; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/minisys_mdu_if.sv
// Request/result bundle between the EXE stage (master) and the multiply/divide unit (slave).
interface minisys_mdu_if #(parameter int WIDTH = 32);
    // start is a request taken on a rising edge only when busy=0 and cancel=0; there is
    // no ready/backpressure beyond busy, and a start seen while busy=1 is dropped.
    // done pulses for exactly one cycle, in which hi/lo already hold the new result.
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opa, opb, cancel,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, cancel,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/minisys_mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when non-negative.
module minisys_mdu_divstep #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, in_bit};
        diff     = shifted - {1'b0, divisor};
        qbit     = ~diff[WIDTH];
        rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/minisys_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; MTHI/MTLO complete in the
// accepting cycle, multi-cycle ops finish WIDTH+1 cycles after acceptance.
module minisys_mdu
    import minisys_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clrn,
    minisys_mdu_if.slave       bus,
    output mdu_state_e         dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [MDU_MAX_WIDTH-1:0] DBZ_FILL = dbz_lo_fill(WIDTH);

    mdu_state_e         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   dividend_raw;
    logic               is_div, neg_res, neg_rem, div_zero;
    logic               busy_r, done_r, dbz_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, rem_step;
    logic               qbit;

    minisys_mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .in_bit   (acc[WIDTH-1]),
        .divisor  (operand),
        .rem_next (rem_step),
        .qbit     (qbit)
    );

    always_comb begin
        signed_op = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        a_neg     = signed_op & bus.opa[WIDTH-1];
        b_neg     = signed_op & bus.opb[WIDTH-1];
        a_mag     = a_neg ? -bus.opa : bus.opa;
        b_mag     = b_neg ? -bus.opb : bus.opb;
        // Multiplier sits in acc's low half and shifts out as the product shifts in.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_next  = {rem_step, acc[WIDTH-2:0], qbit};
        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            acc          <= '0;
            operand      <= '0;
            dividend_raw <= '0;
            is_div       <= 1'b0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            dbz_r        <= 1'b0;
            hi_r         <= '0;
            lo_r         <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        case (bus.op)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                state        <= S_CALC;
                                busy_r       <= 1'b1;
                                cnt          <= CW'(WIDTH - 1);
                                is_div       <= bus.op[1];
                                neg_res      <= a_neg ^ b_neg;
                                neg_rem      <= a_neg;
                                div_zero     <= (bus.opb == '0);
                                dividend_raw <= bus.opa;
                                dbz_r        <= 1'b0;
                                if (bus.op[1]) begin
                                    acc     <= {{WIDTH{1'b0}}, a_mag};
                                    operand <= b_mag;
                                end else begin
                                    acc     <= {{WIDTH{1'b0}}, b_mag};
                                    operand <= a_mag;
                                end
                            end
                            MDU_MTHI: begin
                                hi_r  <= bus.opa;
                                dbz_r <= 1'b0;
                            end
                            MDU_MTLO: begin
                                lo_r  <= bus.opa;
                                dbz_r <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (bus.cancel) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        if (cnt == '0) state <= S_FIX;
                        else           cnt   <= cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    if (!bus.cancel) begin
                        done_r <= 1'b1;
                        if (!is_div) begin
                            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            // Dividend passes through untouched; quotient saturates to all ones.
                            hi_r  <= dividend_raw;
                            lo_r  <= DBZ_FILL[WIDTH-1:0];
                            dbz_r <= 1'b1;
                        end else begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign dbg_state       = state;
endmodule

// File: tb/tb_minisys_mdu.sv
// Randomised and directed checks of minisys_mdu (WIDTH=32 and WIDTH=8 builds)
// against an arithmetic reference model.
module tb_minisys_mdu;
    import minisys_mdu_pkg::*;

    logic clk;
    logic clrn;
    int   n_vec;
    int   n_err;
    logic [31:0] exp_hi, exp_lo;

    minisys_mdu_if #(.WIDTH(32)) m32 ();
    minisys_mdu_if #(.WIDTH(8))  m8 ();
    mdu_state_e st32, st8;

    minisys_mdu #(.WIDTH(32)) u_dut32 (.clk(clk), .clrn(clrn), .bus(m32), .dbg_state(st32));
    minisys_mdu #(.WIDTH(8))  u_dut8  (.clk(clk), .clrn(clrn), .bus(m8),  .dbg_state(st8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from plain signed/unsigned 64-bit arithmetic.
    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            MDU_MULT:  p = 64'(sa * sb);
            MDU_MULTU: p = {32'd0, a} * {32'd0, b};
            MDU_DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            MDU_DIVU: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = {exp_hi, exp_lo};
        endcase
        return p;
    endfunction

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
        m32.start = 1'b1; m32.op = op; m32.opa = a; m32.opb = b;
        tick();
        m32.start = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!m32.done && lat < 100);
        rhi = m32.hi;
        rlo = m32.lo;
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        #2;
        n_vec++; if (m32.busy !== 1'b0 || m32.done !== 1'b0 || m32.div_by_zero !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: busy=%b done=%b dbz=%b need 000", m32.busy, m32.done, m32.div_by_zero); end
        n_vec++; if (m32.hi !== 32'd0 || m32.lo !== 32'd0) begin
            n_err++; $display("FAIL reset_hilo: hi=%h lo=%h need 0", m32.hi, m32.lo); end
        n_vec++; if (st32 !== S_IDLE) begin
            n_err++; $display("FAIL reset_state: got %0d need %0d", st32, S_IDLE); end
        tick();
        clrn = 1'b0;
        tick();
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_mult();
        logic [31:0] h, l; int lat;
        run32(MDU_MULT, 32'hFFFF_FFFD, 32'd7, h, l, lat);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mult_latency: got %0d need 33", lat); end
        n_vec++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
            n_err++; $display("FAIL mult_neg: got %h_%h need ffffffff_ffffffeb", h, l); end
        n_vec++; if (m32.busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_done: got %b need 0", m32.busy); end
        tick();
        n_vec++; if (m32.done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b need 0", m32.done); end
        exp_hi = h; exp_lo = l;
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l; int lat;
        run32(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, lat);
        n_vec++; if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin
            n_err++; $display("FAIL multu_max: got %h_%h need fffffffe_00000001", h, l); end
        // Issued in the done cycle, so it must be accepted immediately.
        run32(MDU_DIVU, 32'd100, 32'd7, h, l, lat);
        n_vec++; if (lat !== 33 || h !== 32'd2 || l !== 32'd14) begin
            n_err++; $display("FAIL back_to_back: lat=%0d hi=%h lo=%h need 33/2/e", lat, h, l); end
        exp_hi = h; exp_lo = l;
    endtask

    task automatic test_div();
        logic [31:0] h, l; int lat;
        run32(MDU_DIV, 32'hFFFF_FFF9, 32'd2, h, l, lat);
        n_vec++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
            n_err++; $display("FAIL div_neg: got %h_%h need ffffffff_fffffffd", h, l); end
        run32(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l, lat);
        n_vec++; if (h !== 32'd0 || l !== 32'h8000_0000 || m32.div_by_zero !== 1'b0) begin
            n_err++; $display("FAIL div_ovf: got %h_%h dbz=%b need 00000000_80000000 0", h, l, m32.div_by_zero); end
        exp_hi = h; exp_lo = l;
    endtask

    task automatic test_div_zero();
        logic [31:0] h, l; int lat;
        run32(MDU_DIVU, 32'd7, 32'd0, h, l, lat);
        n_vec++; if (lat !== 33 || h !== 32'd7 || l !== 32'hFFFF_FFFF || m32.div_by_zero !== 1'b1) begin
            n_err++; $display("FAIL divu_zero: lat=%0d %h_%h dbz=%b need 33 00000007_ffffffff 1", lat, h, l, m32.div_by_zero); end
        repeat (5) tick();
        n_vec++; if (m32.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_hold: got %b need 1", m32.div_by_zero); end
        m32.start = 1'b1; m32.op = MDU_DIVU; m32.opa = 32'd9; m32.opb = 32'd3;
        tick();
        m32.start = 1'b0;
        n_vec++; if (m32.div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_clear: got %b need 0", m32.div_by_zero); end
        while (!m32.done && lat < 200) begin tick(); lat++; end
        exp_hi = m32.hi; exp_lo = m32.lo;
        n_vec++; if (exp_hi !== 32'd0 || exp_lo !== 32'd3) begin
            n_err++; $display("FAIL divu_9_3: got %h_%h need 0_3", exp_hi, exp_lo); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, h, l; logic [2:0] op; logic [63:0] r; int lat;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 3));
                1: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            r = ref_mdu(op, a, b);
            run32(op, a, b, h, l, lat);
            n_vec++; if ({h, l} !== r || lat !== 33) begin
                n_err++; $display("FAIL rand op=%0d a=%h b=%h: got %h_%h lat %0d need %h lat 33", op, a, b, h, l, lat, r); end
            n_vec++; if (m32.div_by_zero !== (op[1] && b == 0)) begin
                n_err++; $display("FAIL rand_dbz op=%0d b=%h: got %b", op, b, m32.div_by_zero); end
            exp_hi = h; exp_lo = l;
        end
    endtask

    task automatic test_cancel();
        int dones;
        m32.start = 1'b1; m32.op = MDU_DIV; m32.opa = $urandom; m32.opb = 32'd5;
        tick();
        m32.start = 1'b0;
        repeat (10) tick();
        m32.cancel = 1'b1;
        tick();
        m32.cancel = 1'b0;
        n_vec++; if (m32.busy !== 1'b0 || st32 !== S_IDLE) begin
            n_err++; $display("FAIL cancel_busy: busy=%b state=%0d need 0/idle", m32.busy, st32); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (m32.done) dones++; end
        n_vec++; if (dones !== 0 || m32.hi !== exp_hi || m32.lo !== exp_lo) begin
            n_err++; $display("FAIL cancel_result: dones=%0d %h_%h need 0 %h_%h", dones, m32.hi, m32.lo, exp_hi, exp_lo); end
        m32.start = 1'b1; m32.cancel = 1'b1; m32.op = MDU_MTHI; m32.opa = ~exp_hi;
        tick();
        m32.start = 1'b0; m32.cancel = 1'b0;
        n_vec++; if (m32.hi !== exp_hi || m32.busy !== 1'b0) begin
            n_err++; $display("FAIL cancel_start: hi=%h busy=%b need %h 0", m32.hi, m32.busy, exp_hi); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] a, b; logic [63:0] r; int lat;
        a = $urandom; b = $urandom;
        r = ref_mdu(MDU_MULT, a, b);
        m32.start = 1'b1; m32.op = MDU_MULT; m32.opa = a; m32.opb = b;
        tick();
        m32.start = 1'b0;
        lat = 0;
        do begin
            m32.start = (lat == 5);
            m32.op = MDU_MTHI; m32.opa = 32'hDEAD_BEEF; m32.opb = 32'd1;
            tick();
            lat++;
        end while (!m32.done && lat < 100);
        m32.start = 1'b0;
        n_vec++; if (lat !== 33 || {m32.hi, m32.lo} !== r) begin
            n_err++; $display("FAIL start_busy: lat=%0d got %h_%h need 33 %h", lat, m32.hi, m32.lo, r); end
        exp_hi = m32.hi; exp_lo = m32.lo;
    endtask

    task automatic test_mt();
        logic [31:0] d;
        m32.start = 1'b1; m32.op = MDU_MTHI; m32.opa = 32'h0000_1234;
        tick();
        m32.start = 1'b0;
        n_vec++; if (m32.hi !== 32'h0000_1234 || m32.busy !== 1'b0 || m32.done !== 1'b0) begin
            n_err++; $display("FAIL mthi: hi=%h busy=%b done=%b need 00001234 0 0", m32.hi, m32.busy, m32.done); end
        exp_hi = 32'h0000_1234;
        d = $urandom;
        m32.start = 1'b1; m32.op = MDU_MTLO; m32.opa = d;
        tick();
        m32.start = 1'b0;
        n_vec++; if (m32.lo !== d || m32.hi !== exp_hi) begin
            n_err++; $display("FAIL mtlo: got %h_%h need %h_%h", m32.hi, m32.lo, exp_hi, d); end
        exp_lo = d;
        m32.start = 1'b1; m32.op = 3'd6; m32.opa = ~d;
        tick();
        m32.start = 1'b0;
        tick();
        n_vec++; if (m32.hi !== exp_hi || m32.lo !== exp_lo || m32.busy !== 1'b0 || m32.done !== 1'b0) begin
            n_err++; $display("FAIL reserved_op: %h_%h busy=%b need %h_%h 0", m32.hi, m32.lo, m32.busy, exp_hi, exp_lo); end
    endtask

    task automatic test_reset_mid();
        m32.start = 1'b1; m32.op = MDU_MULT; m32.opa = $urandom; m32.opb = $urandom;
        tick();
        m32.start = 1'b0;
        repeat (10) tick();
        clrn = 1'b1;
        #1;
        n_vec++; if (m32.hi !== 32'd0 || m32.lo !== 32'd0 || m32.busy !== 1'b0 || st32 !== S_IDLE) begin
            n_err++; $display("FAIL reset_mid: %h_%h busy=%b state=%0d need 0_0 0 idle", m32.hi, m32.lo, m32.busy, st32); end
        tick();
        clrn = 1'b0;
        tick();
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_width8();
        int lat;
        m8.start = 1'b1; m8.op = MDU_MULT; m8.opa = 8'h80; m8.opb = 8'h80;
        tick();
        m8.start = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!m8.done && lat < 100);
        n_vec++; if (lat !== 9 || m8.hi !== 8'h40 || m8.lo !== 8'h00) begin
            n_err++; $display("FAIL w8_mult: lat=%0d %h_%h need 9 40_00", lat, m8.hi, m8.lo); end
        m8.start = 1'b1; m8.op = MDU_DIV; m8.opa = 8'hF9; m8.opb = 8'h02;
        tick();
        m8.start = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!m8.done && lat < 100);
        n_vec++; if (lat !== 9 || m8.hi !== 8'hFF || m8.lo !== 8'hFD) begin
            n_err++; $display("FAIL w8_div: lat=%0d %h_%h need 9 ff_fd", lat, m8.hi, m8.lo); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        exp_hi = '0; exp_lo = '0;
        clrn = 1'b1;
        m32.start = 1'b0; m32.op = '0; m32.opa = '0; m32.opb = '0; m32.cancel = 1'b0;
        m8.start = 1'b0;  m8.op = '0;  m8.opa = '0;  m8.opb = '0;  m8.cancel = 1'b0;
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_div_zero();
        test_random();
        test_cancel();
        test_start_while_busy();
        test_mt();
        test_reset_mid();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/minisys_mdu.md
# minisys_mdu

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the Minisys-1A pipeline. It sits beside the EXE-stage ALU and executes MULT/MULTU/DIV/DIVU over WIDTH cycles, and MTHI/MTLO in a single cycle. It reports busy/done so the hazard logic can stall dependent MF*/MD instructions. Beyond the fixed 32-bit unit, it adds a width parameter, cancel (pipeline flush), and defined divide-by-zero behaviour.

## Interface
- WIDTH, 32, operand/HI/LO width; even, ≥4.
- clk  in  1  system clock; all state changes on the rising edge.
- clrn  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- op  in  3  operation code, sampled with start.
- opa  in  WIDTH  rs operand: multiplicand/dividend, or MTHI/MTLO data.
- opb  in  WIDTH  rt operand: multiplier/divisor.
- cancel  in  1  flush; aborts the in-flight operation.
- busy  out  1  operation in progress (registered).
- done  out  1  one-cycle pulse; HI/LO hold the new result this cycle.
- div_by_zero  out  1  last completed DIV/DIVU had opb=0; held until the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset: busy=0, done=0, div_by_zero=0, hi=0, lo=0, state IDLE, counter=0.
- Ops:
  - MULT=0, MULTU=1, DIV=2, DIVU=3 (multi-cycle).
  - MTHI=4, MTLO=5 (single-cycle).
  - Codes 6–7 are reserved: treated as no-op, no state change.
- States: IDLE, CALC, FIX.
  - IDLE→CALC: start & multi-cycle op & !cancel. Latch operand magnitudes (signed ops: absolute value, result signs recorded), load counter=WIDTH-1.
  - CALC: one step per cycle.
    - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
    - Divide: restoring divide; shift partial remainder, trial-subtract the divisor, set the quotient bit on non-negative.
    - At counter=0 go to FIX; otherwise decrement.
  - FIX: apply signs.
    - Product is negated if the signs differ.
    - Quotient is negated if the signs differ; remainder takes the dividend's sign.
    - Write hi/lo, pulse done, go to IDLE.
- MTHI/MTLO in IDLE: write hi or lo at the accepting edge. busy stays 0; no done pulse.
- Divide by zero:
  - Iteration still runs the full latency.
  - Result: hi=opa (dividend unchanged), lo=all ones; div_by_zero=1 with done.
- Signed overflow (DIV most-negative / −1): lo=most-negative, hi=0. No flag.
- All arithmetic is modulo 2^WIDTH per register. The full 2·WIDTH product is kept, with no truncation.

## Timing
- Accepting edge = E0.
  - busy=1 from E0 through E0+WIDTH.
  - FIX is the cycle after edge E0+WIDTH.
  - hi/lo update and done=1 at edge E0+WIDTH+1; busy=0 in the same cycle.
  - Latency is WIDTH+1 cycles (33 for WIDTH=32).
- A new start is accepted in the done cycle (back-to-back ops).
- start while busy=1 is ignored, with no queuing; the pipeline must stall on busy.
- cancel:
  - In CALC or FIX: next state IDLE, busy=0 the next cycle, hi/lo unchanged, no done, div_by_zero unchanged.
  - cancel & start in IDLE: cancel wins, start is dropped (including MTHI/MTLO).
- clrn mid-operation: outputs immediately take their reset values; the operation is lost.

## Structure
- Package minisys_mdu_pkg holds:
  - op code localparams (MDU_MULT…MDU_MTLO);
  - the state enum (S_IDLE, S_CALC, S_FIX);
  - the divide-by-zero lo constant (all ones, WIDTH-sized through a function).
- Sub-module minisys_mdu_divstep: combinational single restoring-divide step (shift, subtract, select, quotient bit), parametrised by WIDTH.
- Top level contains the FSM, counter, accumulator, and the sign-fix/negation logic.

## Test plan
- MULT opa=0xFFFFFFFD (−3), opb=7 → done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high for one cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; then an immediate start in the done cycle is accepted.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 7/0 → hi=0x00000007, lo=0xFFFFFFFF, div_by_zero=1, held until the next start.
- Cancel:
  - Pulse cancel 10 cycles into a DIV → busy=0 the next cycle, hi/lo unchanged, no done.
  - start while busy → ignored; the original result still arrives at 33 cycles.
- MTHI 0x1234 in IDLE → hi=0x00001234 after one edge, busy stays 0.
- Reset: assert clrn mid-CALC → hi=lo=0 and busy=0 immediately.
- WIDTH=8 build: MULT 0x80×0x80 → hi=0x40, lo=0x00, latency 9.
